// File: rtl/cpu_pkg.sv
// Shared encodings for the pipelined CPU execute/memory stage.
//   - ALU op encodings from the main control unit (ID/EX)
//   - R-type funct field constants (instruction[5:0])
//   - 4-bit ALU operation codes driven to the main ALU
package cpu_pkg;

    // Main-control ALU op
    localparam logic [1:0] ALUOP_MEM = 2'b00;  // lw/sw address add
    localparam logic [1:0] ALUOP_BR  = 2'b01;  // beq compare subtract
    localparam logic [1:0] ALUOP_R   = 2'b10;  // R-type, decode funct

    // R-type funct field
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;

    // ALU operation codes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_NOR = 4'b1100;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALU-control decoder (purely combinational, no clock or reset).
// Ports:
//   alu_op    in  [1:0]  ALU op from main control
//   funct     in  [5:0]  instruction[5:0]
//   operation out [3:0]  ALU operation code
// alu_op=11 is not produced by the main control; it is treated as add so
// the output stays defined for every input combination.
module alu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] operation
);

    always_comb begin
        operation = OP_ADD;
        case (alu_op)
            ALUOP_MEM: operation = OP_ADD;
            ALUOP_BR:  operation = OP_SUB;
            ALUOP_R: begin
                case (funct)
                    FUNCT_ADD: operation = OP_ADD;
                    FUNCT_SUB: operation = OP_SUB;
                    FUNCT_AND: operation = OP_AND;
                    FUNCT_OR:  operation = OP_OR;
                    FUNCT_SLT: operation = OP_SLT;
                    FUNCT_NOR: operation = OP_NOR;
                    // The all-zero pipeline bubble lands here as sll.
                    FUNCT_SLL: operation = OP_SLL;
                    FUNCT_SRL: operation = OP_SRL;
                    default:   operation = OP_ADD;
                endcase
            end
            default:   operation = OP_ADD;
        endcase
    end

endmodule

// File: rtl/ex_mem_datapath_unit.sv
// Execute/memory-stage support block: ALU-control decoder plus a
// word-addressed data memory (combinational read, synchronous write).
// Ports:
//   clk        in        system clock, state changes on posedge
//   rst_n      in        asynchronous active-low reset, clears memory
//   alu_op     in  [1:0] ALU op from main control (ID/EX)
//   funct      in  [5:0] instruction[5:0] (ID/EX)
//   operation  out [3:0] ALU operation code
//   mem_addr   in  [31:0] byte address (EX/MEM ALU result)
//   mem_wdata  in  [31:0] store data
//   mem_read   in        load enable; rdata is zero when low
//   mem_write  in        store enable
//   mem_rdata  out [31:0] load data, valid in the same cycle
module ex_mem_datapath_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    output logic [3:0]  operation,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] mem_rdata
);

    alu_ctrl_decode u_alu_ctrl (
        .alu_op    (alu_op),
        .funct     (funct),
        .operation (operation)
    );

    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [ADDR_W-1:0] word_idx;

    // Byte offset and bits above the array are dropped, so addresses wrap
    // modulo DEPTH_WORDS*4.
    assign word_idx = mem_addr[ADDR_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    // Reset clears every word asynchronously and blocks any write that was
    // set up for the coming edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_write) begin
            mem_q[word_idx] <= mem_wdata;
        end
    end

    // No write bypass: a same-cycle write becomes visible after the edge.
    assign mem_rdata = mem_read ? mem_q[word_idx] : 32'h0;

endmodule

// File: tb/tb_ex_mem_datapath_unit.sv
module tb_ex_mem_datapath_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [3:0]  operation;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    ex_mem_datapath_unit #(.DEPTH_WORDS(256), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_op    (alu_op),
        .funct     (funct),
        .operation (operation),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    // clock: period 10, starts low
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Store one word; inputs change after negedge, write lands on posedge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_addr  = addr;
        mem_wdata = data;
        mem_write = 1'b1;
        mem_read  = 1'b0;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    // Combinational read, sampled 1 time unit after the inputs settle.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        mem_addr = addr;
        mem_read = 1'b1;
        #1;
        check(tag, mem_rdata, exp);
        mem_read = 1'b0;
    endtask

    // Decode vectors with hand-computed codes
    logic [1:0] dv_op    [14];
    logic [5:0] dv_funct [14];
    logic [3:0] dv_exp   [14];

    initial begin
        dv_op[0]  = 2'b00; dv_funct[0]  = 6'b101010; dv_exp[0]  = 4'b0010;
        dv_op[1]  = 2'b01; dv_funct[1]  = 6'b100000; dv_exp[1]  = 4'b0110;
        dv_op[2]  = 2'b11; dv_funct[2]  = 6'b100010; dv_exp[2]  = 4'b0010;
        dv_op[3]  = 2'b10; dv_funct[3]  = 6'b100000; dv_exp[3]  = 4'b0010;
        dv_op[4]  = 2'b10; dv_funct[4]  = 6'b100010; dv_exp[4]  = 4'b0110;
        dv_op[5]  = 2'b10; dv_funct[5]  = 6'b100100; dv_exp[5]  = 4'b0000;
        dv_op[6]  = 2'b10; dv_funct[6]  = 6'b100101; dv_exp[6]  = 4'b0001;
        dv_op[7]  = 2'b10; dv_funct[7]  = 6'b101010; dv_exp[7]  = 4'b0111;
        dv_op[8]  = 2'b10; dv_funct[8]  = 6'b100111; dv_exp[8]  = 4'b1100;
        dv_op[9]  = 2'b10; dv_funct[9]  = 6'b000000; dv_exp[9]  = 4'b1000;
        dv_op[10] = 2'b10; dv_funct[10] = 6'b000010; dv_exp[10] = 4'b1001;
        dv_op[11] = 2'b10; dv_funct[11] = 6'b111111; dv_exp[11] = 4'b0010;
        dv_op[12] = 2'b00; dv_funct[12] = 6'b000000; dv_exp[12] = 4'b0010;
        dv_op[13] = 2'b01; dv_funct[13] = 6'b111111; dv_exp[13] = 4'b0110;
    end

    initial begin
        rst_n     = 1'b0;
        alu_op    = 2'b00;
        funct     = 6'b000000;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_read  = 1'b0;
        mem_write = 1'b0;

        // Decode sweep (combinational, independent of reset)
        #1;
        for (int i = 0; i < 14; i++) begin
            alu_op = dv_op[i];
            funct  = dv_funct[i];
            #1;
            check($sformatf("decode_%0d", i), {28'h0, operation}, {28'h0, dv_exp[i]});
        end

        // Reset held for 2 cycles, memory reads zero
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_read("reset_addr0", 32'd0, 32'h0);
        do_read("reset_addr4", 32'd4, 32'h0);
        do_read("reset_addr1020", 32'd1020, 32'h0);

        // Write/read, low address bits ignored, read disable gates to zero
        do_write(32'd8, 32'hDEADBEEF);
        do_read("rd_addr8", 32'd8, 32'hDEADBEEF);
        do_read("rd_addr9", 32'd9, 32'hDEADBEEF);
        do_read("rd_addr11", 32'd11, 32'hDEADBEEF);
        @(negedge clk);
        mem_addr = 32'd8;
        mem_read = 1'b0;
        #1;
        check("rd_disabled", mem_rdata, 32'h0);
        do_read("rd_addr12_untouched", 32'd12, 32'h0);

        // Wrap: byte address 1024 aliases word 0
        do_write(32'd1024, 32'h12345678);
        do_read("wrap_addr0", 32'd0, 32'h12345678);
        do_read("wrap_addr1024", 32'd1024, 32'h12345678);

        // Same-cycle read and write, old word before edge, new after
        do_write(32'd16, 32'd5);
        @(negedge clk);
        mem_addr  = 32'd16;
        mem_wdata = 32'd7;
        mem_write = 1'b1;
        mem_read  = 1'b1;
        #1;
        check("rw_before_edge", mem_rdata, 32'd5);
        @(posedge clk);
        #1;
        check("rw_after_edge", mem_rdata, 32'd7);
        mem_write = 1'b0;
        mem_read  = 1'b0;

        // Reset mid-run: contents cleared, pending write dropped
        do_write(32'd20, 32'hA5A5A5A5);
        do_read("pre_reset_addr20", 32'd20, 32'hA5A5A5A5);
        @(negedge clk);
        mem_addr  = 32'd20;
        mem_wdata = 32'hFFFFFFFF;
        mem_write = 1'b1;
        mem_read  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_addr20", mem_rdata, 32'h0);
        @(posedge clk);
        #1;
        check("write_blocked_in_reset", mem_rdata, 32'h0);
        @(negedge clk);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        rst_n     = 1'b1;
        do_read("post_reset_addr20", 32'd20, 32'h0);
        do_read("post_reset_addr8", 32'd8, 32'h0);
        do_read("post_reset_addr16", 32'd16, 32'h0);

        // Normal writes resume after reset
        do_write(32'd20, 32'h0BADF00D);
        do_read("resume_addr20", 32'd20, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
